// File: rtl/ball_engine_if.sv
// Signal bundle between the pong ball engine and its paddle controllers,
// renderer and score display.
interface ball_engine_if #(
  parameter int POS_W = 11
);
  // No valid/ready pair: TICK is a one-cycle strobe per frame and the
  // buttons/directions are CLK-synchronous levels; all outputs are registered.
  logic             TICK;
  logic             BTN_A;
  logic             BTN_B;
  logic             A_UP;
  logic             A_DOWN;
  logic             B_UP;
  logic             B_DOWN;
  logic [POS_W-1:0] L_PADDLE_POS;
  logic [POS_W-1:0] R_PADDLE_POS;
  logic [POS_W-1:0] BALL_X;
  logic [POS_W-1:0] BALL_Y;
  logic [3:0]       SPEED;
  logic [3:0]       L_SCORE;
  logic [3:0]       R_SCORE;
  logic             GAME_OVER;
  logic             WINNER;
  logic [2:0]       STATE;

  modport master (
    output TICK, BTN_A, BTN_B, A_UP, A_DOWN, B_UP, B_DOWN,
    output L_PADDLE_POS, R_PADDLE_POS,
    input  BALL_X, BALL_Y, SPEED, L_SCORE, R_SCORE, GAME_OVER, WINNER, STATE
  );

  modport slave (
    input  TICK, BTN_A, BTN_B, A_UP, A_DOWN, B_UP, B_DOWN,
    input  L_PADDLE_POS, R_PADDLE_POS,
    output BALL_X, BALL_Y, SPEED, L_SCORE, R_SCORE, GAME_OVER, WINNER, STATE
  );
endinterface

// File: rtl/ball_engine.sv
// Pong ball/score engine: ball motion on TICK, wall and paddle bounces,
// rally speed-up, and the serve/play/point/game-over sequencing.
module ball_engine #(
  parameter int SCR_W            = 30,
  parameter int SCR_H            = 20,
  parameter int BALL_W           = 2,
  parameter int BALL_H           = 2,
  parameter int PADDLE_H         = 6,
  parameter int MAX_SCORE        = 9,
  parameter int SPEED_MAX        = 3,
  parameter int HITS_PER_SPEEDUP = 4,
  parameter int POS_W            = 11
) (
  input logic          CLK,
  input logic          RST,
  ball_engine_if.slave bus
);
  localparam int PW1   = POS_W + 1;
  localparam int HIT_W = $clog2(HITS_PER_SPEEDUP + 1);

  localparam logic [POS_W-1:0] INIT_X = POS_W'(SCR_W / 2 - 1);
  localparam logic [POS_W-1:0] INIT_Y = POS_W'(SCR_H / 2 - 1);
  localparam logic [POS_W-1:0] YMIN   = POS_W'(1);
  localparam logic [POS_W-1:0] YMAX   = POS_W'(SCR_H - 1 - BALL_H);
  localparam logic [POS_W-1:0] L_FACE = POS_W'(3);
  localparam logic [POS_W-1:0] R_FACE = POS_W'(SCR_W - 3 - BALL_W);
  localparam logic [POS_W-1:0] XMAX   = POS_W'(SCR_W - BALL_W);
  localparam logic [HIT_W-1:0] HITS_TGT  = HIT_W'(HITS_PER_SPEEDUP);
  localparam logic [HIT_W-1:0] HIT_ONE   = HIT_W'(1);
  localparam logic [3:0]       SPD_MAX   = 4'(SPEED_MAX);
  localparam logic [3:0]       SCORE_MAX = 4'(MAX_SCORE);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE_L = 3'd1,
    SERVE_R = 3'd2,
    PLAY    = 3'd3,
    POINT   = 3'd4,
    OVER    = 3'd5
  } state_t;

  state_t           state_q, state_n;
  logic [POS_W-1:0] x_q, x_n, y_q, y_n;
  logic             dx_q, dx_n;  // 1 = moving right
  logic             dy_q, dy_n;  // 1 = moving down
  logic [3:0]       speed_q, speed_n;
  logic [HIT_W-1:0] hits_q, hits_n;
  logic [3:0]       l_q, l_n, r_q, r_n;
  logic             winner_q, winner_n;
  logic             scorer_q, scorer_n;  // 1 = right player scored
  logic             game_over_q, game_over_n;
  logic             a_q, b_q;

  logic             a_rise, b_rise, hit, srv_up, srv_dn;
  logic [POS_W-1:0] s_w;
  logic [3:0]       l_inc, r_inc;

  // Ball rows [y, y+BALL_H-1] intersect paddle rows [pad, pad+PADDLE_H-1].
  function automatic logic overlap(input logic [POS_W-1:0] y,
                                   input logic [POS_W-1:0] pad);
    logic [PW1-1:0] y_bot, p_bot;
    y_bot = {1'b0, y} + PW1'(BALL_H - 1);
    p_bot = {1'b0, pad} + PW1'(PADDLE_H - 1);
    return (y_bot >= {1'b0, pad}) && ({1'b0, y} <= p_bot);
  endfunction

  assign a_rise = bus.BTN_A & ~a_q;
  assign b_rise = bus.BTN_B & ~b_q;
  assign s_w    = POS_W'(speed_q);
  assign l_inc  = l_q + 4'd1;
  assign r_inc  = r_q + 4'd1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      x_q         <= INIT_X;
      y_q         <= INIT_Y;
      dx_q        <= 1'b1;
      dy_q        <= 1'b1;
      speed_q     <= 4'd1;
      hits_q      <= '0;
      l_q         <= '0;
      r_q         <= '0;
      winner_q    <= 1'b0;
      scorer_q    <= 1'b0;
      game_over_q <= 1'b0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
    end else begin
      state_q     <= state_n;
      x_q         <= x_n;
      y_q         <= y_n;
      dx_q        <= dx_n;
      dy_q        <= dy_n;
      speed_q     <= speed_n;
      hits_q      <= hits_n;
      l_q         <= l_n;
      r_q         <= r_n;
      winner_q    <= winner_n;
      scorer_q    <= scorer_n;
      game_over_q <= game_over_n;
      a_q         <= bus.BTN_A;
      b_q         <= bus.BTN_B;
    end
  end

  always_comb begin
    state_n  = state_q;
    x_n      = x_q;
    y_n      = y_q;
    dx_n     = dx_q;
    dy_n     = dy_q;
    speed_n  = speed_q;
    hits_n   = hits_q;
    l_n      = l_q;
    r_n      = r_q;
    winner_n = winner_q;
    scorer_n = scorer_q;
    hit      = 1'b0;
    srv_up   = 1'b0;
    srv_dn   = 1'b0;
    case (state_q)
      IDLE: begin
        if (a_rise)      state_n = SERVE_L;
        else if (b_rise) state_n = SERVE_R;
      end
      SERVE_L, SERVE_R: begin
        srv_up = (state_q == SERVE_L) ? bus.A_UP   : bus.B_UP;
        srv_dn = (state_q == SERVE_L) ? bus.A_DOWN : bus.B_DOWN;
        if (srv_up)      dy_n = 1'b0;
        else if (srv_dn) dy_n = 1'b1;
        dx_n    = (state_q == SERVE_L);
        state_n = PLAY;
      end
      PLAY: begin
        if (bus.TICK) begin
          if (dy_q) begin
            if (y_q + s_w >= YMAX) begin y_n = YMAX; dy_n = 1'b0; end
            else                   y_n = y_q + s_w;
          end else begin
            if (y_q <= YMIN + s_w) begin y_n = YMIN; dy_n = 1'b1; end
            else                   y_n = y_q - s_w;
          end
          // Paddle test uses the pre-tick row; crossing the face snaps to it.
          if (dx_q) begin
            if (x_q < R_FACE) begin
              if (x_q + s_w >= R_FACE) begin
                x_n = R_FACE;
                if (overlap(y_q, bus.R_PADDLE_POS)) begin dx_n = 1'b0; hit = 1'b1; end
              end else x_n = x_q + s_w;
            end else if (x_q + s_w >= XMAX) begin
              x_n = XMAX; scorer_n = 1'b0; state_n = POINT;
            end else x_n = x_q + s_w;
          end else begin
            if (x_q > L_FACE) begin
              if (x_q <= L_FACE + s_w) begin
                x_n = L_FACE;
                if (overlap(y_q, bus.L_PADDLE_POS)) begin dx_n = 1'b1; hit = 1'b1; end
              end else x_n = x_q - s_w;
            end else if (x_q <= s_w) begin
              x_n = '0; scorer_n = 1'b1; state_n = POINT;
            end else x_n = x_q - s_w;
          end
          if (hit) begin
            if (hits_q + HIT_ONE == HITS_TGT) begin
              hits_n = '0;
              if (speed_q < SPD_MAX) speed_n = speed_q + 4'd1;
            end else hits_n = hits_q + HIT_ONE;
          end
        end
      end
      POINT: begin
        if (!scorer_q) begin
          l_n = l_inc;
          if (l_inc == SCORE_MAX) begin state_n = OVER; winner_n = 1'b0; end
          else                          state_n = SERVE_R;
        end else begin
          r_n = r_inc;
          if (r_inc == SCORE_MAX) begin state_n = OVER; winner_n = 1'b1; end
          else                          state_n = SERVE_L;
        end
      end
      OVER: begin
        if (a_rise || b_rise) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Entering idle or a serve recentres the ball and restarts the rally.
    if (state_n inside {IDLE, SERVE_L, SERVE_R}) begin
      x_n     = INIT_X;
      y_n     = INIT_Y;
      speed_n = 4'd1;
      hits_n  = '0;
    end
    if (state_n == IDLE) begin
      l_n = '0;
      r_n = '0;
    end
    game_over_n = (state_n == OVER);
  end

  assign bus.BALL_X    = x_q;
  assign bus.BALL_Y    = y_q;
  assign bus.SPEED     = speed_q;
  assign bus.L_SCORE   = l_q;
  assign bus.R_SCORE   = r_q;
  assign bus.GAME_OVER = game_over_q;
  assign bus.WINNER    = winner_q;
  assign bus.STATE     = state_q;
endmodule

// File: tb/tb_ball_engine.sv
// Directed bench for ball_engine with MAX_SCORE = 2: serve, walls, misses,
// rally speed-up to saturation, game over, async reset and button priority.
module tb_ball_engine;
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  ball_engine_if #(.POS_W(11)) bus();

  ball_engine #(.MAX_SCORE(2)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct packed {
    logic        tick;
    logic        btn_a;
    logic        a_up;
    logic [10:0] ex;
    logic [10:0] ey;
    logic [3:0]  ls;
    logic [2:0]  st;
  } vec_t;

  vec_t        vecs[$];
  logic [10:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          bx [14] = '{13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
  int          by [14] = '{10, 11, 12, 13, 14, 15, 16, 17, 16, 15, 14, 13, 12, 11};

  function automatic vec_t mk(input logic tick, input logic ba, input logic au,
                              input int ex, input int ey, input int ls, input int st);
    vec_t v;
    v.tick = tick; v.btn_a = ba; v.a_up = au;
    v.ex = 11'(ex); v.ey = 11'(ey); v.ls = 4'(ls); v.st = 3'(st);
    return v;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic check_snap(input string name, input int ex, input int ey, input int spd,
                            input int ls, input int rs, input int st, input int go);
    check({name, ".x"},     32'(bus.BALL_X),    ex);
    check({name, ".y"},     32'(bus.BALL_Y),    ey);
    check({name, ".speed"}, 32'(bus.SPEED),     spd);
    check({name, ".lsc"},   32'(bus.L_SCORE),   ls);
    check({name, ".rsc"},   32'(bus.R_SCORE),   rs);
    check({name, ".state"}, 32'(bus.STATE),     st);
    check({name, ".go"},    32'(bus.GAME_OVER), go);
  endtask

  // Paddles either sit on the ball row or are parked well clear of it.
  task automatic tick_once(input bit avoid_l, input bit avoid_r);
    bus.L_PADDLE_POS = avoid_l ? ((bus.BALL_Y < 9) ? 11'd15 : 11'd0) : bus.BALL_Y;
    bus.R_PADDLE_POS = avoid_r ? ((bus.BALL_Y < 9) ? 11'd15 : 11'd0) : bus.BALL_Y;
    bus.TICK = 1'b1;
    step();
    bus.TICK = 1'b0;
  endtask

  task automatic leg(input int start, input int dir, input int s, input int steps,
                     input int face, input int spd_after, input bit avoid_r);
    for (int k = 1; k < steps; k++) exp_q.push_back(11'(start + dir * k * s));
    exp_q.push_back(11'(face));
    for (int k = 1; k <= steps; k++) begin
      tick_once(1'b0, avoid_r);
      check("leg.x", 32'(bus.BALL_X), 32'(exp_q.pop_front()));
    end
    check("leg.speed", 32'(bus.SPEED), spd_after);
    check("leg.state", 32'(bus.STATE), 3);
  endtask

  initial begin
    RST = 1'b1;
    bus.TICK = 1'b0; bus.BTN_A = 1'b0; bus.BTN_B = 1'b0;
    bus.A_UP = 1'b0; bus.A_DOWN = 1'b0; bus.B_UP = 1'b0; bus.B_DOWN = 1'b0;
    bus.L_PADDLE_POS = 11'd0; bus.R_PADDLE_POS = 11'd15;
    repeat (2) @(posedge CLK);
    #1;
    check_snap("reset", 14, 9, 1, 0, 0, 0, 0);
    @(negedge CLK);
    RST = 1'b0;

    // Serve with A_UP, a TICK in the serve cycle, top wall, right-side miss.
    vecs.push_back(mk(0, 0, 0, 14, 9, 0, 0));
    vecs.push_back(mk(0, 1, 1, 14, 9, 0, 1));
    vecs.push_back(mk(1, 0, 1, 14, 9, 0, 3));
    vecs.push_back(mk(1, 0, 0, 15, 8, 0, 3));
    vecs.push_back(mk(0, 0, 0, 15, 8, 0, 3));
    vecs.push_back(mk(1, 0, 0, 16, 7, 0, 3));
    vecs.push_back(mk(1, 0, 0, 17, 6, 0, 3));
    vecs.push_back(mk(1, 0, 0, 18, 5, 0, 3));
    vecs.push_back(mk(1, 0, 0, 19, 4, 0, 3));
    vecs.push_back(mk(1, 0, 0, 20, 3, 0, 3));
    vecs.push_back(mk(1, 0, 0, 21, 2, 0, 3));
    vecs.push_back(mk(1, 0, 0, 22, 1, 0, 3));
    vecs.push_back(mk(1, 0, 0, 23, 2, 0, 3));
    vecs.push_back(mk(1, 0, 0, 24, 3, 0, 3));
    vecs.push_back(mk(1, 0, 0, 25, 4, 0, 3));
    vecs.push_back(mk(1, 0, 0, 26, 5, 0, 3));
    vecs.push_back(mk(1, 0, 0, 27, 6, 0, 3));
    vecs.push_back(mk(1, 0, 0, 28, 7, 0, 4));
    vecs.push_back(mk(0, 0, 0, 14, 9, 1, 2));
    vecs.push_back(mk(0, 0, 0, 14, 9, 1, 3));
    for (int i = 0; i < vecs.size(); i++) begin
      bus.TICK = vecs[i].tick; bus.BTN_A = vecs[i].btn_a; bus.A_UP = vecs[i].a_up;
      step();
      check_snap($sformatf("vec%0d", i), 32'(vecs[i].ex), 32'(vecs[i].ey), 1,
                 32'(vecs[i].ls), 0, 32'(vecs[i].st), 0);
    end
    bus.TICK = 1'b0; bus.BTN_A = 1'b0; bus.A_UP = 1'b0;

    // Rally with tracking paddles: speed 1 -> 2 -> 3, then saturates.
    leg(14, -1, 1, 11, 3, 1, 1'b0);
    leg(3, 1, 1, 22, 25, 1, 1'b0);
    leg(25, -1, 1, 22, 3, 1, 1'b0);
    leg(3, 1, 1, 22, 25, 2, 1'b0);
    leg(25, -1, 2, 11, 3, 2, 1'b0);
    leg(3, 1, 2, 11, 25, 2, 1'b0);
    leg(25, -1, 2, 11, 3, 2, 1'b0);
    leg(3, 1, 2, 11, 25, 3, 1'b0);
    leg(25, -1, 3, 8, 3, 3, 1'b0);
    leg(3, 1, 3, 8, 25, 3, 1'b0);
    leg(25, -1, 3, 8, 3, 3, 1'b0);
    leg(3, 1, 3, 8, 25, 3, 1'b0);
    leg(25, -1, 3, 8, 3, 3, 1'b0);
    // Right paddle parked away: reach the face, then the edge -> game over.
    leg(3, 1, 3, 8, 25, 3, 1'b1);
    tick_once(1'b0, 1'b1);
    check("miss2.x", 32'(bus.BALL_X), 28);
    check("miss2.state", 32'(bus.STATE), 4);
    step();
    check_snap("over", 28, 32'(bus.BALL_Y), 3, 2, 0, 5, 1);
    check("over.winner", 32'(bus.WINNER), 0);
    tick_once(1'b0, 1'b0);
    check("over.tick.x", 32'(bus.BALL_X), 28);
    check("over.tick.state", 32'(bus.STATE), 5);

    bus.BTN_B = 1'b1;
    step();
    check_snap("to_idle", 14, 9, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("b_held.state", 32'(bus.STATE), 0);
    end
    bus.BTN_B = 1'b0;
    step();
    bus.BTN_B = 1'b1; bus.B_DOWN = 1'b1;
    step();
    check("serve_r.state", 32'(bus.STATE), 2);
    bus.BTN_B = 1'b0;
    step();
    check_snap("serve_r.play", 14, 9, 1, 0, 0, 3, 0);
    bus.B_DOWN = 1'b0;

    // Bottom wall at y=16/17, then the left player misses.
    for (int t = 0; t < 14; t++) begin
      tick_once(t >= 10, 1'b0);
      check($sformatf("bot%0d.x", t), 32'(bus.BALL_X), bx[t]);
      check($sformatf("bot%0d.y", t), 32'(bus.BALL_Y), by[t]);
    end
    check("miss_l.state", 32'(bus.STATE), 4);
    step();
    check_snap("miss_l.point", 14, 9, 1, 0, 1, 1, 0);
    step();
    check("miss_l.play", 32'(bus.STATE), 3);

    // Asynchronous reset mid-cycle while scores are non-zero.
    #2;
    RST = 1'b1;
    #1;
    check_snap("async_rst", 14, 9, 1, 0, 0, 0, 0);
    @(negedge CLK);
    RST = 1'b0;

    // Both buttons rise together: A wins; A_UP beats A_DOWN.
    bus.BTN_A = 1'b1; bus.BTN_B = 1'b1; bus.A_UP = 1'b1; bus.A_DOWN = 1'b1;
    step();
    check("both.state", 32'(bus.STATE), 1);
    step();
    check("both.play", 32'(bus.STATE), 3);
    bus.BTN_A = 1'b0; bus.BTN_B = 1'b0; bus.A_UP = 1'b0; bus.A_DOWN = 1'b0;
    tick_once(1'b0, 1'b0);
    check("both.x", 32'(bus.BALL_X), 15);
    check("both.y", 32'(bus.BALL_Y), 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ball_engine.md
# ball_engine

Parametrised ball/score engine for the pong datapath. It keeps the ball position, direction and speed, bounces the ball off the walls and paddles, and keeps both players' scores through serve, play, point and game-over phases. Motion advances only on a frame-rate `TICK` strobe, and speed steps up as a rally lengthens. It sits between the paddle controllers (paddle positions in) and the pixel renderer / score display (ball position and scores out).

## Interface
- `SCR_W`, 30, playfield width in cells
- `SCR_H`, 20, playfield height in cells
- `BALL_W`, 2, ball width
- `BALL_H`, 2, ball height
- `PADDLE_H`, 6, paddle height
- `MAX_SCORE`, 9, winning score (1..15)
- `SPEED_MAX`, 3, maximum cells moved per tick (1..15)
- `HITS_PER_SPEEDUP`, 4, paddle hits per speed increment (>=1)
- `POS_W`, 11, position width
- `CLK`  in  1  system clock
- `RST`  in  1  reset, asynchronous, active-high
- `TICK`  in  1  single-cycle movement strobe, one per frame
- `BTN_A`, `BTN_B`  in  1  start/serve buttons (levels, synchronous to CLK)
- `A_UP`, `A_DOWN`, `B_UP`, `B_DOWN`  in  1  paddle direction levels
- `L_PADDLE_POS`, `R_PADDLE_POS`  in  POS_W  paddle top row
- `BALL_X`, `BALL_Y`  out  POS_W  ball top-left cell
- `SPEED`  out  4  current step size
- `L_SCORE`, `R_SCORE`  out  4  scores
- `GAME_OVER`  out  1  high in OVER
- `WINNER`  out  1  0 = left, 1 = right; valid when GAME_OVER = 1
- `STATE`  out  3  state code, for debug

## Operation
- Derived constants: INIT_X = SCR_W/2-1; INIT_Y = SCR_H/2-1; YMIN = 1; YMAX = SCR_H-1-BALL_H; L_FACE = 3; R_FACE = SCR_W-3-BALL_W; XMAX = SCR_W-BALL_W.
- Buttons are rising-edge detected internally against a registered previous value. If both buttons rise in the same cycle, A wins.
- States: IDLE=0, SERVE_L=1, SERVE_R=2, PLAY=3, POINT=4, OVER=5.
- IDLE:
  - Ball held at (INIT_X, INIT_Y); scores 0; GAME_OVER 0.
  - Rise of A goes to SERVE_L; rise of B goes to SERVE_R.
- SERVE_L / SERVE_R:
  - Ball held at the initial position; SPEED = 1; hit count = 0.
  - The server's UP sets dy = up; otherwise the server's DOWN sets dy = down. UP has priority.
  - dx is set toward the opponent; go to PLAY.
  - This transition does not wait for TICK.
- PLAY: on TICK, with s = SPEED:
  - Vertical, moving down: if y+s >= YMAX, then y = YMAX and dy flips; else y += s.
  - Vertical, moving up: if y <= YMIN+s, then y = YMIN and dy flips; else y -= s.
  - Horizontal, moving right with x < R_FACE and x+s >= R_FACE: x = R_FACE.
    - If the pre-tick y overlaps the right paddle (y+BALL_H-1 >= R_PADDLE_POS and y <= R_PADDLE_POS+PADDLE_H-1), dx flips and the hit count increments.
  - Horizontal, moving right with x >= R_FACE: x = min(x+s, XMAX). Reaching XMAX means the left player scores and the state goes to POINT.
  - Moving left mirrors this with L_FACE and the left paddle. The edge is 0 and the right player scores.
  - Horizontal and vertical updates are applied in the same tick.
- Speed-up: when the hit count reaches HITS_PER_SPEEDUP, it clears and SPEED increments, saturating at SPEED_MAX.
- POINT: one cycle. The scorer's score increments.
  - If the new value equals MAX_SCORE: go to OVER with WINNER = scorer.
  - Else go to the conceding player's serve state (left scored goes to SERVE_R).
- OVER: ball and scores hold; GAME_OVER = 1. A rise of either button goes to IDLE.
- The L_SCORE / R_SCORE widths are fixed at 4 bits. No score wrap is possible, because MAX_SCORE <= 15 ends the game.

## Timing
- Reset values: BALL_X = INIT_X, BALL_Y = INIT_Y, SPEED = 1, scores 0, GAME_OVER 0, WINNER 0, STATE IDLE. Direction is right/down, hit count 0, edge registers 0.
- All outputs are registered. A TICK in cycle n updates BALL_X/BALL_Y in cycle n+1.
- A button rise in cycle n changes STATE in cycle n+1. A button held high does not retrigger.
- The scoring tick enters POINT next cycle; the score updates and the state leaves POINT one cycle later.
- TICK is ignored outside PLAY. A TICK coinciding with the serve transition cycle does not move the ball.
- RST mid-play returns every output to its reset value immediately (asynchronous), including the scores.
- A wall flip and a paddle flip may occur on the same tick; both apply.

## Test plan
- Reset: assert RST during PLAY -> next sample shows BALL = (14,9), scores 0/0, STATE 0, GAME_OVER 0.
- Serve: pulse BTN_A, hold A_UP, then one TICK -> STATE goes 1 -> 3, and the ball moves to (15,8).
- Wall bounce: ball moving down at y=16 with SPEED 1 -> after TICK y=17; after the next TICK y=16.
- Paddle hit and speed-up: R_PADDLE_POS=5, ball reaches x=25 with y=8 -> dx flips. After the 4th hit SPEED=2 and the ball then moves 2 cells per tick. SPEED saturates at 3.
- Miss: R_PADDLE_POS=15, ball moving right at y=4 -> x advances to 28; STATE goes to 4, then 2; L_SCORE = 1; ball recentred.
- Game over: MAX_SCORE=2, two right-side misses -> STATE=5, GAME_OVER=1, WINNER=0. A BTN_B rise -> IDLE with scores 0/0. Holding BTN_B does not retrigger.
